// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM controller slice.
// Holds the run-state enum, the default counter width and the
// active-low 7-segment digit codes (segment order {g,f,e,d,c,b,a}).
package pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_t;

  localparam int PERIOD_BITS_DEF = 4;

  localparam logic [6:0] SEG7_0     = 7'h40;
  localparam logic [6:0] SEG7_1     = 7'h79;
  localparam logic [6:0] SEG7_2     = 7'h24;
  localparam logic [6:0] SEG7_3     = 7'h30;
  localparam logic [6:0] SEG7_4     = 7'h19;
  localparam logic [6:0] SEG7_5     = 7'h12;
  localparam logic [6:0] SEG7_6     = 7'h02;
  localparam logic [6:0] SEG7_7     = 7'h78;
  localparam logic [6:0] SEG7_8     = 7'h00;
  localparam logic [6:0] SEG7_9     = 7'h10;
  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG7_0;
      4'd1:    seg = SEG7_1;
      4'd2:    seg = SEG7_2;
      4'd3:    seg = SEG7_3;
      4'd4:    seg = SEG7_4;
      4'd5:    seg = SEG7_5;
      4'd6:    seg = SEG7_6;
      4'd7:    seg = SEG7_7;
      4'd8:    seg = SEG7_8;
      4'd9:    seg = SEG7_9;
      default: seg = SEG7_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/pwm_controller_if.sv
// Control/status bundle between the duty source and the PWM controller.
// master: upstream driver of enable and duty; slave: the controller.
interface pwm_controller_if
  import pwm_pkg::*;
#(
  parameter int PERIOD_BITS = PERIOD_BITS_DEF
);
  logic                   en;
  logic [PERIOD_BITS-1:0] duty_in;
  logic                   duty_carry;
  logic                   duty_load;
  logic                   pwm_out;
  logic                   period_start;
  logic [PERIOD_BITS:0]   duty_active;
  logic                   load_pending;

  modport master (
    output en, duty_in, duty_carry, duty_load,
    input  pwm_out, period_start, duty_active, load_pending
  );

  modport slave (
    input  en, duty_in, duty_carry, duty_load,
    output pwm_out, period_start, duty_active, load_pending
  );
endinterface

// File: rtl/seg7_decoder.sv
// Combinational single-digit decoder: 4-bit value to active-low segments.
// Values above 9 blank the digit.
module seg7_decoder
  import pwm_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Table lookup of the segment pattern for one digit
  always_comb begin
    o_seg = seg7_encode(i_digit);
  end

endmodule

// File: rtl/pwm_controller.sv
// PWM controller: free-running phase counter with double-buffered duty.
// A captured duty waits in a shadow register and is applied only when a
// new period begins, so a period is never cut short or stretched.
// Optional feature: define PWM_SEG7_EN to add registered two-digit
// decimal display outputs (seg7_lo / seg7_hi) of the applied duty.
module pwm_controller
  import pwm_pkg::*;
#(
  parameter int PERIOD_BITS = PERIOD_BITS_DEF
)
(
  input  logic             clk,
  input  logic             rst,
`ifdef PWM_SEG7_EN
  output logic [6:0]       seg7_lo,
  output logic [6:0]       seg7_hi,
`endif
  pwm_controller_if.slave  ctl
);

  localparam logic [PERIOD_BITS:0] DUTY_FULL = {1'b1, {PERIOD_BITS{1'b0}}};

  pwm_state_t             r_state;
  logic [PERIOD_BITS-1:0] r_phase;
  logic                   r_pwm;
  logic                   r_pstart;
  logic                   r_pending;
  logic [PERIOD_BITS:0]   r_duty;
  logic [PERIOD_BITS:0]   r_shadow;

  logic [PERIOD_BITS:0]   w_capture;
  logic [PERIOD_BITS-1:0] w_phase_next;
  logic                   w_enter_p0;
  logic [PERIOD_BITS:0]   w_duty_next;

  // Next phase, period-boundary detection and the duty that the next cycle uses.
  // A load coinciding with the boundary bypasses the shadow so it is applied at once.
  always_comb begin
    w_capture    = ctl.duty_carry ? DUTY_FULL : {1'b0, ctl.duty_in};
    w_phase_next = (r_state == RUN) ? r_phase + 1'b1 : '0;
    w_enter_p0   = ctl.en && ((r_state == IDLE) || (w_phase_next == '0));
    w_duty_next  = r_duty;
    if (w_enter_p0) begin
      if (ctl.duty_load) begin
        w_duty_next = w_capture;
      end else if (r_pending) begin
        w_duty_next = r_shadow;
      end
    end
  end

  // Run/idle FSM with phase counter, registered waveform and duty buffering
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_phase   <= '0;
      r_pwm     <= 1'b0;
      r_pstart  <= 1'b0;
      r_pending <= 1'b0;
      r_duty    <= '0;
      r_shadow  <= '0;
    end else begin
      if (ctl.duty_load) begin
        r_shadow <= w_capture;
      end
      r_duty <= w_duty_next;
      if (w_enter_p0) begin
        r_pending <= 1'b0;
      end else if (ctl.duty_load) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_phase <= '0;
          if (ctl.en) begin
            r_state  <= RUN;
            r_pstart <= 1'b1;
            r_pwm    <= (w_duty_next != '0);
          end else begin
            r_pstart <= 1'b0;
            r_pwm    <= 1'b0;
          end
        end
        RUN: begin
          if (ctl.en) begin
            r_phase  <= w_phase_next;
            r_pstart <= w_enter_p0;
            r_pwm    <= ({1'b0, w_phase_next} < w_duty_next);
          end else begin
            r_state  <= IDLE;
            r_phase  <= '0;
            r_pstart <= 1'b0;
            r_pwm    <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_phase  <= '0;
          r_pstart <= 1'b0;
          r_pwm    <= 1'b0;
        end
      endcase
    end
  end

  assign ctl.pwm_out      = r_pwm;
  assign ctl.period_start = r_pstart;
  assign ctl.duty_active  = r_duty;
  assign ctl.load_pending = r_pending;

`ifdef PWM_SEG7_EN
  // Split into tens/ones assumes the applied duty stays below 20 (0..16 by default)
  localparam logic [PERIOD_BITS:0] DEC_TEN = (PERIOD_BITS+1)'(10);

  logic [3:0] w_tens;
  logic [3:0] w_ones;
  logic [6:0] w_seg_lo;
  logic [6:0] w_seg_hi;
  logic [6:0] r_seg_lo;
  logic [6:0] r_seg_hi;

  // Decimal split of the applied duty
  always_comb begin
    w_tens = '0;
    w_ones = 4'(r_duty);
    if (r_duty >= DEC_TEN) begin
      w_tens = 4'd1;
      w_ones = 4'(r_duty - DEC_TEN);
    end
  end

  seg7_decoder u_seg_lo (.i_digit(w_ones), .o_seg(w_seg_lo));
  seg7_decoder u_seg_hi (.i_digit(w_tens), .o_seg(w_seg_hi));

  // Register the display so it shows "00" out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_lo <= SEG7_0;
      r_seg_hi <= SEG7_0;
    end else begin
      r_seg_lo <= w_seg_lo;
      r_seg_hi <= w_seg_hi;
    end
  end

  assign seg7_lo = r_seg_lo;
  assign seg7_hi = r_seg_hi;
`endif

endmodule

// File: tb/tb_pwm_controller.sv
// Self-checking bench for pwm_controller: directed vector table, directed
// multi-cycle sequences and random stimulus against a period/duty model.
module tb_pwm_controller;
  import pwm_pkg::*;

  localparam int PB = 4;
  localparam int P  = 1 << PB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_controller_if #(.PERIOD_BITS(PB)) ctl ();

`ifdef PWM_SEG7_EN
  logic [6:0] seg7_lo;
  logic [6:0] seg7_hi;
`endif

  pwm_controller #(.PERIOD_BITS(PB)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef PWM_SEG7_EN
    .seg7_lo (seg7_lo),
    .seg7_hi (seg7_hi),
`endif
    .ctl     (ctl)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int g_hi     = 0;

  // Reference model: where we are in the period and which duty applies
  bit m_run;
  int m_phase;
  int m_duty;
  int m_shadow;
  bit m_pend;

  typedef struct {
    bit       en;
    bit       load;
    bit       carry;
    bit [3:0] din;
    bit       pwm;
    bit       ps;
    int       duty;
    bit       pend;
  } vec_t;

  vec_t tbl[10];

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_run = 0; m_phase = 0; m_duty = 0; m_shadow = 0; m_pend = 0;
  endtask

  // One rising edge of the model, using the inputs as sampled at that edge
  task automatic model_edge();
    int cap;
    bit start_period;
    cap = ctl.duty_carry ? P : int'(ctl.duty_in);
    start_period = ctl.en && (!m_run || m_phase == P - 1);
    if (!ctl.en)          m_phase = 0;
    else if (start_period) m_phase = 0;
    else                   m_phase = m_phase + 1;
    if (start_period) begin
      if (ctl.duty_load) m_duty = cap;
      else if (m_pend)   m_duty = m_shadow;
      m_pend = 0;
    end else if (ctl.duty_load) begin
      m_pend = 1;
    end
    if (ctl.duty_load) m_shadow = cap;
    m_run = ctl.en;
  endtask

  task automatic check_model();
    check("model_pwm_out",      int'(ctl.pwm_out),      (m_run && m_phase < m_duty) ? 1 : 0);
    check("model_period_start", int'(ctl.period_start), (m_run && m_phase == 0) ? 1 : 0);
    check("model_duty_active",  int'(ctl.duty_active),  m_duty);
    check("model_load_pending", int'(ctl.load_pending), int'(m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    g_hi += int'(ctl.pwm_out);
    check_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_load(input bit carry, input bit [3:0] din);
    ctl.duty_load  = 1'b1;
    ctl.duty_carry = carry;
    ctl.duty_in    = din;
    step();
    ctl.duty_load  = 1'b0;
    ctl.duty_carry = 1'b0;
  endtask

  // Reset asserted between edges must clear outputs without waiting for clk
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_pwm_out",      int'(ctl.pwm_out),      0);
    check("rst_async_period_start", int'(ctl.period_start), 0);
    check("rst_async_duty_active",  int'(ctl.duty_active),  0);
    check("rst_async_load_pending", int'(ctl.load_pending), 0);
    @(posedge clk);
    #1;
`ifdef PWM_SEG7_EN
    check("rst_seg7_lo", int'(seg7_lo), int'(7'h40));
    check("rst_seg7_hi", int'(seg7_hi), int'(7'h40));
`endif
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    ctl.en         = 1'b0;
    ctl.duty_in    = '0;
    ctl.duty_carry = 1'b0;
    ctl.duty_load  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pwm_out",      int'(ctl.pwm_out),      0);
    check("reset_period_start", int'(ctl.period_start), 0);
    check("reset_duty_active",  int'(ctl.duty_active),  0);
    check("reset_load_pending", int'(ctl.load_pending), 0);
    rst = 1'b0;

    // {en, load, carry, din} -> {pwm, period_start, duty_active, load_pending}
    tbl[0] = '{1'b0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 0,  1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4,  1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4,  1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4,  1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4,  1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4,  1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 4,  1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4,  1'b1};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 16, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 16, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ctl.en         = tbl[i].en;
      ctl.duty_load  = tbl[i].load;
      ctl.duty_carry = tbl[i].carry;
      ctl.duty_in    = tbl[i].din;
      step();
      check($sformatf("vec%0d_pwm_out", i),      int'(ctl.pwm_out),      int'(tbl[i].pwm));
      check($sformatf("vec%0d_period_start", i), int'(ctl.period_start), int'(tbl[i].ps));
      check($sformatf("vec%0d_duty_active", i),  int'(ctl.duty_active),  tbl[i].duty);
      check($sformatf("vec%0d_load_pending", i), int'(ctl.load_pending), int'(tbl[i].pend));
    end
    ctl.duty_load  = 1'b0;
    ctl.duty_carry = 1'b0;

    // Duty 4 loaded in IDLE: 4 high / 12 low, period_start every 16
    async_reset();
    ctl.en = 1'b0;
    pulse_load(1'b0, 4'd4);
    ctl.en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < P; k++) begin
        step();
        check("duty4_pwm_out",      int'(ctl.pwm_out),      (k < 4) ? 1 : 0);
        check("duty4_period_start", int'(ctl.period_start), (k == 0) ? 1 : 0);
      end
    end

    // Saturated load in the last phase: applied at the very next phase 0
    pulse_load(1'b1, 4'd3);
    check("sat_duty_active",  int'(ctl.duty_active),  16);
    check("sat_period_start", int'(ctl.period_start), 1);
    g_hi = int'(ctl.pwm_out);
    steps(P - 1);
    check("sat_high_count", g_hi, 16);

    // Running duty 8, load 2 at phase 5: pending phases 6..15, applied next period
    g_hi = 0;
    pulse_load(1'b0, 4'd8);
    check("d8_duty_active", int'(ctl.duty_active), 8);
    steps(5);
    pulse_load(1'b0, 4'd2);
    check("d8_pending_ph6", int'(ctl.load_pending), 1);
    for (int k = 7; k < P; k++) begin
      step();
      check("d8_pending_hold", int'(ctl.load_pending), 1);
    end
    check("d8_high_count", g_hi, 8);
    g_hi = 0;
    step();
    check("d2_duty_active",  int'(ctl.duty_active),  2);
    check("d2_pending_clr",  int'(ctl.load_pending), 0);
    steps(P - 1);
    check("d2_high_count", g_hi, 2);

    // Two loads in one period: last one wins
    step();
    steps(2);
    pulse_load(1'b0, 4'd5);
    step();
    pulse_load(1'b0, 4'd9);
    check("lastwin_pending", int'(ctl.load_pending), 1);
    steps(10);
    check("lastwin_old_duty", int'(ctl.duty_active), 2);
    g_hi = 0;
    step();
    check("lastwin_duty_active", int'(ctl.duty_active), 9);
    steps(P - 1);
    check("lastwin_high_count", g_hi, 9);

    // en dropped at phase 3 aborts the period; re-enable restarts cleanly
    pulse_load(1'b0, 4'd8);
    steps(3);
    ctl.en = 1'b0;
    step();
    check("abort_pwm_out",      int'(ctl.pwm_out),      0);
    check("abort_period_start", int'(ctl.period_start), 0);
    ctl.en = 1'b1;
    g_hi = 0;
    step();
    check("restart_period_start", int'(ctl.period_start), 1);
    steps(P - 1);
    check("restart_high_count", g_hi, 8);

    // Reset at phase 7 with a load pending discards everything
    step();
    steps(5);
    pulse_load(1'b0, 4'd3);
    step();
    check("pre_rst_pending", int'(ctl.load_pending), 1);
    async_reset();

    // Random stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      ctl.en         = ($urandom_range(0, 9) != 0);
      ctl.duty_load  = ($urandom_range(0, 5) == 0);
      ctl.duty_carry = ($urandom_range(0, 7) == 0);
      ctl.duty_in    = 4'($urandom);
      if ($urandom_range(0, 299) == 0) async_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench can never hang
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
